// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
//
// Purpose:
//   Sequences one instruction at a time through the flag-update path of a small
//   CPU. ALU_F / CMP results are latched into flags_out and written to the flag
//   register with a one-cycle flag_write pulse. ALU_NF completes without writing.
//   BRANCH evaluates a condition code against the current flag register and
//   holds the decision on branch_taken until the next BRANCH completes.
//
//   Optional feature, selected by the macro FLAG_CTRL_STACK_EN:
//     a 2-entry LIFO flag stack. push saves stored_flags and pop restores the
//     top entry through the normal WRITE/DONE path. Misuse sets the sticky
//     stack_err. Without the macro, push/pop are ignored, no stack storage
//     exists and stack_err is tied low.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         sequence one instruction (sampled in IDLE only)
//   op[1:0]       00 ALU_F, 01 ALU_NF, 10 CMP, 11 BRANCH
//   cond[2:0]     branch condition code (BRANCH only)
//   alu_flags     ALU flags {N,C,V,Z}
//   stored_flags  current flag register contents {N,C,V,Z}
//   push / pop    flag stack requests (IDLE only, start has priority)
//   flags_out     registered data for the flag register
//   flag_write    one-cycle flag register write enable
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   branch_taken  registered branch decision
//   stack_err     sticky stack misuse flag
// -----------------------------------------------------------------------------
module flag_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [3:0] stored_flags,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags_out,
    output logic       flag_write,
    output logic       busy,
    output logic       done,
    output logic       branch_taken,
    output logic       stack_err
);

    localparam logic [1:0] OP_ALU_F  = 2'b00;
    localparam logic [1:0] OP_ALU_NF = 2'b01;
    localparam logic [1:0] OP_CMP    = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_WRITE = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q;
    logic [1:0] op_q;
    logic [2:0] cond_q;
    logic       cond_true;

    // Condition evaluation against the live flag register (bit0=Z, bit1=V,
    // bit2=C, bit3=N); only consumed on the EVAL -> DONE edge.
    always_comb begin
        cond_true = 1'b0;
        case (cond_q)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = stored_flags[0];
            3'b010:  cond_true = ~stored_flags[0];
            3'b011:  cond_true = stored_flags[2];
            3'b100:  cond_true = ~stored_flags[2];
            3'b101:  cond_true = stored_flags[1];
            3'b110:  cond_true = stored_flags[3];
            default: cond_true = 1'b0;
        endcase
    end

`ifdef FLAG_CTRL_STACK_EN
    logic [3:0] stack_q [2];
    logic [1:0] depth_q;
    logic       stack_err_q;
    logic       stack_req;
    logic       push_ok;
    logic       pop_ok;
    logic       stack_bad;

    // Stack requests are only honoured in IDLE and lose to start.
    // Entry index: push writes slot depth[0]; the top entry sits in slot depth[1]
    // (depth 1 -> slot 0, depth 2 -> slot 1).
    always_comb begin
        stack_req = (state_q == S_IDLE) && !start;
        push_ok   = stack_req && push && !pop && (depth_q != 2'd2);
        pop_ok    = stack_req && pop && !push && (depth_q != 2'd0);
        stack_bad = stack_req && (push || pop) && !push_ok && !pop_ok;
    end

    assign stack_err = stack_err_q;
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = push ^ pop;
    assign stack_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_ALU_F;
            cond_q       <= 3'b000;
            flags_out    <= 4'b0000;
            flag_write   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
`ifdef FLAG_CTRL_STACK_EN
            depth_q      <= 2'd0;
            stack_err_q  <= 1'b0;
`endif
        end else begin
            // Pulsed outputs default low; states that need them re-assert.
            flag_write <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        cond_q  <= cond;
                        busy    <= 1'b1;
                        state_q <= S_EXEC;
                    end
`ifdef FLAG_CTRL_STACK_EN
                    else if (pop_ok) begin
                        // Restore goes straight to WRITE, skipping EXEC.
                        flags_out  <= stack_q[depth_q[1]];
                        flag_write <= 1'b1;
                        busy       <= 1'b1;
                        depth_q    <= depth_q - 2'd1;
                        state_q    <= S_WRITE;
                    end else if (push_ok) begin
                        stack_q[depth_q[0]] <= stored_flags;
                        depth_q             <= depth_q + 2'd1;
                    end
                    if (stack_bad) begin
                        stack_err_q <= 1'b1;
                    end
`endif
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ALU_F, OP_CMP: begin
                            flags_out  <= alu_flags;
                            flag_write <= 1'b1;
                            state_q    <= S_WRITE;
                        end
                        OP_ALU_NF: begin
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end
                        OP_BRANCH: begin
                            state_q <= S_EVAL;
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
                S_WRITE: begin
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_EVAL: begin
                    branch_taken <= cond_true;
                    done         <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_ctrl
//
// Directed testbench for flag_ctrl. A transaction-level model turns each
// accepted request into a list of per-cycle output phases; a compare process
// checks every DUT output against that model on every cycle after reset.
// Hand-computed literal checks pin the latencies and values of each scenario.
// Builds with or without FLAG_CTRL_STACK_EN.
// -----------------------------------------------------------------------------
module tb_flag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [2:0] cond;
    logic [3:0] alu_flags;
    logic [3:0] stored_flags;
    logic       push;
    logic       pop;
    logic [3:0] flags_out;
    logic       flag_write;
    logic       busy;
    logic       done;
    logic       branch_taken;
    logic       stack_err;

`ifdef FLAG_CTRL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    flag_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .stored_flags(stored_flags),
        .push        (push),
        .pop         (pop),
        .flags_out   (flags_out),
        .flag_write  (flag_write),
        .busy        (busy),
        .done        (done),
        .branch_taken(branch_taken),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------------------------------------------------------- model
    // One phase per cycle after an accepted request: what the outputs show and
    // which value gets captured on the edge that enters that phase.
    typedef struct packed {
        logic busy;
        logic done;
        logic fw;
        logic load_alu;
        logic load_pop;
        logic eval;
    } phase_t;

    phase_t     sched[$];
    phase_t     ph;
    logic [3:0] m_stack[$];
    logic [3:0] m_flags;
    logic [3:0] m_pop_val;
    logic [2:0] m_cond;
    logic       m_bt, m_err, m_busy, m_done, m_fw;
    bit         m_valid = 1'b0;

    function automatic phase_t mk(input logic b, input logic d, input logic f,
                                  input logic la, input logic lp, input logic ev);
        phase_t p;
        p.busy = b; p.done = d; p.fw = f;
        p.load_alu = la; p.load_pop = lp; p.eval = ev;
        return p;
    endfunction

    function automatic logic branch_rule(input logic [2:0] c, input logic [3:0] f);
        logic z, v, cy, n;
        z = f[0]; v = f[1]; cy = f[2]; n = f[3];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return v;
            3'd6: return n;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sched.delete();
            m_stack.delete();
            m_flags = 4'b0000; m_bt = 1'b0; m_err = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_fw = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (sched.size() == 0) begin
                if (start) begin
                    m_cond = cond;
                    sched.push_back(mk(1, 0, 0, 0, 0, 0));          // execute
                    case (op)
                        2'b01: sched.push_back(mk(1, 1, 0, 0, 0, 0));
                        2'b11: begin
                            sched.push_back(mk(1, 0, 0, 0, 0, 0));
                            sched.push_back(mk(1, 1, 0, 0, 0, 1));
                        end
                        default: begin
                            sched.push_back(mk(1, 0, 1, 1, 0, 0));
                            sched.push_back(mk(1, 1, 0, 0, 0, 0));
                        end
                    endcase
                end else if (STACK_EN && push && pop) begin
                    m_err = 1'b1;
                end else if (STACK_EN && push) begin
                    if (m_stack.size() >= 2) m_err = 1'b1;
                    else m_stack.push_back(stored_flags);
                end else if (STACK_EN && pop) begin
                    if (m_stack.size() == 0) m_err = 1'b1;
                    else begin
                        m_pop_val = m_stack.pop_back();
                        sched.push_back(mk(1, 0, 1, 0, 1, 0));
                        sched.push_back(mk(1, 1, 0, 0, 0, 0));
                    end
                end
            end
            if (sched.size() > 0) begin
                ph = sched.pop_front();
                m_busy = ph.busy; m_done = ph.done; m_fw = ph.fw;
                if (ph.load_alu) m_flags = alu_flags;
                if (ph.load_pop) m_flags = m_pop_val;
                if (ph.eval)     m_bt = branch_rule(m_cond, stored_flags);
            end else begin
                m_busy = 1'b0; m_done = 1'b0; m_fw = 1'b0;
            end
        end
    end

    // Per-cycle compare, on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_tests++;
            if ({flags_out, flag_write, busy, done, branch_taken, stack_err} !==
                {m_flags, m_fw, m_busy, m_done, m_bt, m_err}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got flags=%b fw=%b busy=%b done=%b bt=%b err=%b required flags=%b fw=%b busy=%b done=%b bt=%b err=%b",
                         $time, flags_out, flag_write, busy, done, branch_taken, stack_err,
                         m_flags, m_fw, m_busy, m_done, m_bt, m_err);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    logic [2:0] br_cond  [9] = '{3'b001, 3'b010, 3'b111, 3'b000, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010};
    logic [3:0] br_flags [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b1000, 4'b0000};
    logic       br_exp   [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; push = 1'b0; pop = 1'b0;
        op = 2'b00; cond = 3'b000; alu_flags = 4'b0000; stored_flags = 4'b0000;
        cyc(); cyc();

        // Reset overrides a simultaneous start.
        start = 1'b1; op = 2'b00; alu_flags = 4'b1111;
        cyc();
        $display("[TB] txn reset with start op=00 alu=1111");
        chk("rst_flags", flags_out, 4'b0000);
        chk("rst_ctrl", {flag_write, busy, done, branch_taken}, 4'b0000);
        chk("rst_err", {3'b000, stack_err}, 4'b0000);
        rst = 1'b0; start = 1'b0;
        cyc();
        chk("rst_no_fw", {3'b000, flag_write}, 4'b0000);
        chk("rst_idle", {3'b000, busy}, 4'b0000);
        cyc();

        // ALU_F with a stray start in the EXEC cycle.
        op = 2'b00; alu_flags = 4'b0101; start = 1'b1;
        cyc();                                         // cycle 1
        $display("[TB] txn ALU_F alu=0101");
        chk("aluf_c1_busy_fw", {2'b00, busy, flag_write}, 4'b0010);
        op = 2'b01;                                    // start still high: ignored
        cyc();                                         // cycle 2
        start = 1'b0;
        chk("aluf_c2_fw", {3'b000, flag_write}, 4'b0001);
        chk("aluf_c2_flags", flags_out, 4'b0101);
        chk("aluf_c2_done", {3'b000, done}, 4'b0000);
        cyc();                                         // cycle 3
        chk("aluf_c3_done_fw", {2'b00, done, flag_write}, 4'b0010);
        cyc();
        chk("aluf_idle", {2'b00, busy, done}, 4'b0000);
        cyc();
        chk("aluf_no_requeue", {2'b00, busy, flag_write}, 4'b0000);

        // ALU_NF: no write, done in cycle 2.
        op = 2'b01; alu_flags = 4'b1111; start = 1'b1;
        cyc();
        start = 1'b0;
        $display("[TB] txn ALU_NF alu=1111");
        chk("alunf_c1_fw", {3'b000, flag_write}, 4'b0000);
        cyc();
        chk("alunf_c2_done", {2'b00, done, flag_write}, 4'b0010);
        chk("alunf_flags_held", flags_out, 4'b0101);
        cyc();
        chk("alunf_idle", {3'b000, busy}, 4'b0000);

        // CMP writes flags like ALU_F.
        op = 2'b10; alu_flags = 4'b1010; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        $display("[TB] txn CMP alu=1010");
        chk("cmp_c2_fw", {3'b000, flag_write}, 4'b0001);
        chk("cmp_c2_flags", flags_out, 4'b1010);
        cyc();
        chk("cmp_c3_done", {3'b000, done}, 4'b0001);
        cyc();

        // BRANCH condition table.
        for (int i = 0; i < 9; i++) begin
            op = 2'b11; cond = br_cond[i]; stored_flags = br_flags[i]; start = 1'b1;
            cyc();
            start = 1'b0;
            cyc();
            chk("br_c2_done", {3'b000, done}, 4'b0000);
            cyc();
            $display("[TB] txn BRANCH cond=%b stored=%b taken=%b", cond, stored_flags, branch_taken);
            chk("br_c3_done", {3'b000, done}, 4'b0001);
            chk("br_taken", {3'b000, branch_taken}, {3'b000, br_exp[i]});
            cyc();
            chk("br_held", {3'b000, branch_taken}, {3'b000, br_exp[i]});
        end
        chk("br_no_write", flags_out, 4'b1010);

`ifdef FLAG_CTRL_STACK_EN
        stored_flags = 4'b0100; push = 1'b1;
        cyc();
        stored_flags = 4'b0010;
        chk("push1", {1'b0, busy, flag_write, stack_err}, 4'b0000);
        cyc();
        stored_flags = 4'b1111;
        chk("push2", {3'b000, stack_err}, 4'b0000);
        cyc();
        push = 1'b0;
        $display("[TB] txn push 0100, push 0010, push overflow");
        chk("push_overflow_err", {3'b000, stack_err}, 4'b0001);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        $display("[TB] txn pop -> %b", flags_out);
        chk("pop1_flags", flags_out, 4'b0010);
        chk("pop1_fw", {2'b00, busy, flag_write}, 4'b0011);
        cyc();
        chk("pop1_done", {2'b00, done, flag_write}, 4'b0010);
        cyc();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        $display("[TB] txn pop -> %b", flags_out);
        chk("pop2_flags", flags_out, 4'b0100);
        chk("pop2_fw", {3'b000, flag_write}, 4'b0001);
        cyc(); cyc();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        $display("[TB] txn pop underflow");
        chk("pop_underflow", {1'b0, busy, flag_write, stack_err}, 4'b0001);
        chk("pop_underflow_flags", flags_out, 4'b0100);

        rst = 1'b1; cyc(); rst = 1'b0;
        chk("stk_rst_err", {3'b000, stack_err}, 4'b0000);
        push = 1'b1; pop = 1'b1; stored_flags = 4'b0110;
        cyc();
        push = 1'b0; pop = 1'b0;
        $display("[TB] txn push+pop together");
        chk("pushpop_err", {2'b00, flag_write, stack_err}, 4'b0001);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("pushpop_not_stored", {2'b00, flag_write, busy}, 4'b0000);

        rst = 1'b1; cyc(); rst = 1'b0;
        op = 2'b01; start = 1'b1; push = 1'b1; stored_flags = 4'b1001;
        cyc();
        start = 1'b0; push = 1'b0;
        $display("[TB] txn start with push");
        chk("start_push_err", {3'b000, stack_err}, 4'b0000);
        cyc(); cyc();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("start_push_dropped", {2'b00, flag_write, stack_err}, 4'b0001);
        cyc();
`else
        push = 1'b1; stored_flags = 4'b0110;
        cyc();
        push = 1'b0; pop = 1'b1;
        cyc();
        pop = 1'b0;
        $display("[TB] txn push/pop without stack");
        chk("nostack_pop", {1'b0, busy, flag_write, stack_err}, 4'b0000);
        chk("nostack_flags", flags_out, 4'b1010);
        push = 1'b1; pop = 1'b1;
        cyc();
        push = 1'b0; pop = 1'b0;
        chk("nostack_err", {3'b000, stack_err}, 4'b0000);
        cyc();
`endif

        // Reset during the WRITE cycle aborts the sequence.
        op = 2'b00; alu_flags = 4'b0011; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();                                         // WRITE cycle
        chk("abort_write_fw", {3'b000, flag_write}, 4'b0001);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        $display("[TB] txn reset in WRITE");
        chk("abort_ctrl", {1'b0, flag_write, busy, done}, 4'b0000);
        chk("abort_flags", flags_out, 4'b0000);
        cyc();
        chk("abort_no_done", {2'b00, done, flag_write}, 4'b0000);
        cyc();
        chk("abort_idle", {2'b00, busy, flag_write}, 4'b0000);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
